// File: rtl/bin2bcd_disp_feed.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_disp_feed
//  Purpose  : Sequential binary-to-BCD converter (shift-add-3, one iteration
//             per clock) feeding an 8-digit seven-segment display driver.
//             Saturates inputs above 99 999 999 and optionally blanks leading
//             zero digits.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        system clock, rising edge
//    rst_n_i      synchronous active-low reset
//    start_i      conversion request, sampled only while idle
//    bin_in_i     unsigned binary value (BIN_W bits)
//    busy_o       high while a conversion is in progress
//    done_o       one-cycle pulse when new results are valid
//    ovf_o        last conversion was saturated
//    hex_out_o    8 packed BCD digits, digit 0 in [3:0]
//    disp_en_o    per-digit enables, bit k enables digit k
// ============================================================================
module bin2bcd_disp_feed #(
   parameter int BIN_W    = 27,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [BIN_W-1:0] bin_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o,
   output logic [31:0]      hex_out_o,
   output logic [7:0]       disp_en_o
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_SHIFT  = 2'd1;
   localparam logic [1:0]  S_FINISH = 2'd2;
   localparam logic [26:0] C_MAX    = 27'd99_999_999;

   logic [1:0]       state_q,   state_d;
   logic [4:0]       cnt_q,     cnt_d;
   logic [BIN_W-1:0] bin_q,     bin_d;
   logic [31:0]      bcd_q,     bcd_d;
   logic             ovf_lat_q, ovf_lat_d;
   logic [31:0]      hex_q,     hex_d;
   logic [7:0]       en_q,      en_d;
   logic             ovf_q,     ovf_d;
   logic             done_q,    done_d;

   logic [26:0]      w_bin_ext;
   logic             w_ovf;
   logic [26:0]      w_load;
   logic [31:0]      w_adj;
   logic [7:0]       w_en;
   logic             w_any;

   // Saturation is decided on the 27-bit zero-extended value; for BIN_W<27
   // the input can never exceed the limit, so truncation back is lossless.
   assign w_bin_ext = 27'(bin_in_i);
   assign w_ovf     = (w_bin_ext > C_MAX);
   assign w_load    = w_ovf ? C_MAX : w_bin_ext;

   // Add 3 to every nibble >= 5 before the shift (double-dabble correction).
   always_comb begin
      w_adj = bcd_q;
      for (int k = 0; k < 8; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            w_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
   end

   // Digit k is lit when any digit at or above k is nonzero; digit 0 is
   // always lit so a zero result still shows "0".
   always_comb begin
      w_en  = 8'h01;
      w_any = 1'b0;
      for (int k = 7; k >= 1; k--) begin
         w_any   = w_any | (bcd_q[4*k +: 4] != 4'd0);
         w_en[k] = w_any;
      end
      if (!BLANK_LZ) begin
         w_en = 8'hFF;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      ovf_lat_d = ovf_lat_q;
      hex_d     = hex_q;
      en_d      = en_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               bin_d     = w_load[BIN_W-1:0];
               ovf_lat_d = w_ovf;
               bcd_d     = 32'h0;
               cnt_d     = 5'(BIN_W);
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d = {w_adj[30:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            hex_d   = bcd_q;
            en_d    = w_en;
            ovf_d   = ovf_lat_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 5'd0;
         bin_q     <= '0;
         bcd_q     <= 32'h0;
         ovf_lat_q <= 1'b0;
         hex_q     <= 32'h0;
         en_q      <= 8'h01;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         ovf_lat_q <= ovf_lat_d;
         hex_q     <= hex_d;
         en_q      <= en_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = done_q;
   assign ovf_o     = ovf_q;
   assign hex_out_o = hex_q;
   assign disp_en_o = en_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_disp_feed.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin2bcd_disp_feed
//  Purpose  : Directed self-checking bench for bin2bcd_disp_feed; one
//             instance with leading-zero blanking, one without.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_disp_feed;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [26:0] bin_in;

   logic        busy_a, done_a, ovf_a;
   logic [31:0] hex_a;
   logic [7:0]  en_a;
   logic        busy_b, done_b, ovf_b;
   logic [31:0] hex_b;
   logic [7:0]  en_b;

   int n_chk  = 0;
   int n_fail = 0;

   bin2bcd_disp_feed #(.BIN_W(27), .BLANK_LZ(1'b1)) dut_a (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .bin_in_i  (bin_in),
      .busy_o    (busy_a),
      .done_o    (done_a),
      .ovf_o     (ovf_a),
      .hex_out_o (hex_a),
      .disp_en_o (en_a)
   );

   bin2bcd_disp_feed #(.BIN_W(27), .BLANK_LZ(1'b0)) dut_b (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .bin_in_i  (bin_in),
      .busy_o    (busy_b),
      .done_o    (done_b),
      .ovf_o     (ovf_b),
      .hex_out_o (hex_b),
      .disp_en_o (en_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Full conversion: pulse start, check latency, hold, results on both DUTs.
   task automatic do_conv(input logic [26:0] v, input logic [31:0] eh,
                          input logic [7:0] ee, input logic eo);
      logic [31:0] old_hex;
      int          lat;
      old_hex = hex_a;
      start   = 1'b1;
      bin_in  = v;
      @(posedge clk); #1;
      start   = 1'b0;
      bin_in  = 27'd77_777;
      chk("busy_after_start", {31'd0, busy_a}, 32'd1);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 27) chk("hold_hex", hex_a, old_hex);
         if (done_a) begin
            lat = n;
            break;
         end
      end
      chk("latency", lat, 32'd28);
      chk("hex_a", hex_a, eh);
      chk("en_a", {24'd0, en_a}, {24'd0, ee});
      chk("ovf_a", {31'd0, ovf_a}, {31'd0, eo});
      chk("hex_b", hex_b, eh);
      chk("en_b", {24'd0, en_b}, 32'h0000_00FF);
      @(posedge clk); #1;
      chk("done_pulse_end", {31'd0, done_a}, 32'd0);
      chk("busy_end", {31'd0, busy_a}, 32'd0);
   endtask

   initial begin
      int dones;
      logic [31:0] hex_at_done;
      rst_n  = 1'b0;
      start  = 1'b0;
      bin_in = 27'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_hex", hex_a, 32'h0);
      chk("rst_en", {24'd0, en_a}, 32'h01);
      chk("rst_en_b", {24'd0, en_b}, 32'h01);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_done", {31'd0, done_a}, 32'd0);
      chk("rst_ovf", {31'd0, ovf_a}, 32'd0);

      do_conv(27'd12_345_678,  32'h12345678, 8'hFF, 1'b0);
      do_conv(27'd1_000,       32'h00001000, 8'h0F, 1'b0);
      do_conv(27'd0,           32'h00000000, 8'h01, 1'b0);
      do_conv(27'd9,           32'h00000009, 8'h01, 1'b0);
      do_conv(27'd100_000_000, 32'h99999999, 8'hFF, 1'b1);
      do_conv(27'd134_217_727, 32'h99999999, 8'hFF, 1'b1);
      do_conv(27'd5,           32'h00000005, 8'h01, 1'b0);

      // Second START while busy must be ignored.
      start  = 1'b1;
      bin_in = 27'd42;
      @(posedge clk); #1;
      start  = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      start  = 1'b1;
      bin_in = 27'd77;
      @(posedge clk); #1;
      start  = 1'b0;
      chk("rej_hold_hex", hex_a, 32'h5);
      dones = 0;
      hex_at_done = 32'h0;
      for (int n = 0; n < 45; n++) begin
         @(posedge clk); #1;
         if (done_a) begin
            dones++;
            hex_at_done = hex_a;
         end
      end
      chk("rej_dones", dones, 32'd1);
      chk("rej_hex", hex_at_done, 32'h42);
      chk("rej_en", {24'd0, en_a}, 32'h03);

      // Reset in the middle of a conversion.
      start  = 1'b1;
      bin_in = 27'd555;
      @(posedge clk); #1;
      start  = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_hex", hex_a, 32'h0);
      chk("mid_rst_en", {24'd0, en_a}, 32'h01);
      chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
      chk("mid_rst_done", {31'd0, done_a}, 32'd0);
      dones = 0;
      for (int n = 0; n < 35; n++) begin
         @(posedge clk); #1;
         if (done_a) dones++;
      end
      chk("mid_rst_no_done", dones, 32'd0);

      do_conv(27'd31, 32'h00000031, 8'h03, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
